// File: rtl/pipe_hazard_ctrl.sv
// Execute-stage hazard controller: tracks EX/MEM/WB destination shadows and
// produces forwarding selects, load-use stalls, branch flushes and
// multicycle-op handshakes.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC  = 1,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_en,
  input  logic       id_rs2_en,
  input  logic [4:0] id_rd,
  input  logic       id_rd_we,
  input  logic       id_is_load,
  input  logic       id_is_mc,
  input  logic       ex_br_taken,
  input  logic       mc_done,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_if,
  output logic       flush_id,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       mc_start,
  output logic       mc_timeout,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MCW   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } shadow_t;

  localparam int unsigned TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mc_start_q, mc_start_d;
  logic          mc_timeout_q, mc_timeout_d;
  logic [1:0]    fwd1_q, fwd1_d;
  logic [1:0]    fwd2_q, fwd2_d;
  shadow_t       ex_q, ex_d;
  shadow_t       mem_q, mem_d;
  shadow_t       wb_q, wb_d;
  logic          lu_hazard;
  logic          issue;
  shadow_t       id_ent;

  function automatic logic hit(input shadow_t s, input logic [4:0] rs, input logic en);
    return s.valid & s.we & (s.rd == rs) & (rs != 5'd0) & en;
  endfunction

  function automatic logic [1:0] fwd_src(input shadow_t ex, input shadow_t mem,
                                         input shadow_t wb, input logic [4:0] rs,
                                         input logic en);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(ex, rs, en))       sel = 2'd1;
    else if (hit(mem, rs, en)) sel = 2'd2;
    else if (hit(wb, rs, en))  sel = 2'd3;
    return sel;
  endfunction

  assign lu_hazard = id_valid & ex_q.load &
                     (hit(ex_q, id_rs1, id_rs1_en) | hit(ex_q, id_rs2, id_rs2_en));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = '0;
    mc_start_d   = 1'b0;
    mc_timeout_d = mc_timeout_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_br_taken) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          cnt_d    = 3'(FLUSH_CYC);
          state_d  = ST_FLUSH;
        end else if (lu_hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_id = 1'b1;
          state_d  = ST_LU;
        end else if (id_valid & id_is_mc) begin
          mc_start_d = 1'b1;
          state_d    = ST_MCW;
        end
      end
      ST_LU: begin
        state_d = ST_RUN;
      end
      ST_MCW: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        // mc_start_q marks the first wait cycle, where mc_done is not trusted
        if (mc_done & ~mc_start_q) begin
          state_d = ST_RUN;
        end else if (tmo_q == TW'(MC_TIMEOUT - 1)) begin
          mc_timeout_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_FLUSH: begin
        flush_if = 1'b1;
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    issue  = id_valid & ~stall_id & ~flush_id;
    id_ent = '{valid: 1'b1, rd: id_rd, we: id_rd_we, load: id_is_load};
    wb_d   = mem_q;
    mem_d  = ex_q;
    ex_d   = '0;
    fwd1_d = 2'd0;
    fwd2_d = 2'd0;
    if (state_q == ST_MCW) begin
      // multicycle op parks in EX: hold it and its selects, drain MEM
      mem_d  = '0;
      ex_d   = ex_q;
      fwd1_d = fwd1_q;
      fwd2_d = fwd2_q;
    end else if (issue) begin
      ex_d   = id_ent;
      fwd1_d = fwd_src(ex_q, mem_q, wb_q, id_rs1, id_rs1_en);
      fwd2_d = fwd_src(ex_q, mem_q, wb_q, id_rs2, id_rs2_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      tmo_q        <= '0;
      mc_start_q   <= 1'b0;
      mc_timeout_q <= 1'b0;
      fwd1_q       <= '0;
      fwd2_q       <= '0;
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      mc_start_q   <= mc_start_d;
      mc_timeout_q <= mc_timeout_d;
      fwd1_q       <= fwd1_d;
      fwd2_q       <= fwd2_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
    end
  end

  assign fwd_rs1_sel = fwd1_q;
  assign fwd_rs2_sel = fwd2_q;
  assign mc_start    = mc_start_q;
  assign mc_timeout  = mc_timeout_q;
  assign state_o     = state_q;

endmodule
